// File: rtl/dmaster_chan_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmaster_chan_arbiter_pkg
// Shared definitions for the packet-aware channel arbiter:
//   - arb_state_e : arbiter FSM encoding (IDLE = no grant, LOCKED = packet owner)
//   - NUM_IN_DEF / DATA_W_DEF / CHAN_W_DEF : default parameter values
//   - idx_w()     : width of an input index for a given input count
// -----------------------------------------------------------------------------
package dmaster_chan_arbiter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  localparam int NUM_IN_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int CHAN_W_DEF = 8;

  // At least one bit, even for a degenerate single-input build.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dmaster_chan_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmaster_chan_arbiter_if
// Bundle of all streaming signals around the arbiter.
//   in_*   : NUM_IN source streams (valid/ready/data/SOP/EOP), input i data at
//            in_data[i*DATA_W +: DATA_W]
//   out_*  : single merged stream plus out_channel (source index)
//   proto_err : sticky per-input framing error flags
// Modports:
//   slave  : the arbiter side (consumes in_*, produces out_*)
//   master : the environment side (sources + downstream sink)
// -----------------------------------------------------------------------------
interface dmaster_chan_arbiter_if
  import dmaster_chan_arbiter_pkg::*;
#(
  parameter int NUM_IN = NUM_IN_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CHAN_W = CHAN_W_DEF
) ();

  logic [NUM_IN-1:0]        in_valid;
  logic [NUM_IN-1:0]        in_ready;
  logic [NUM_IN*DATA_W-1:0] in_data;
  logic [NUM_IN-1:0]        in_startofpacket;
  logic [NUM_IN-1:0]        in_endofpacket;

  logic                     out_ready;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic [CHAN_W-1:0]        out_channel;
  logic                     out_startofpacket;
  logic                     out_endofpacket;

  logic [NUM_IN-1:0]        proto_err;

  modport slave (
    input  in_valid, in_data, in_startofpacket, in_endofpacket, out_ready,
    output in_ready, out_valid, out_data, out_channel,
           out_startofpacket, out_endofpacket, proto_err
  );

  modport master (
    output in_valid, in_data, in_startofpacket, in_endofpacket, out_ready,
    input  in_ready, out_valid, out_data, out_channel,
           out_startofpacket, out_endofpacket, proto_err
  );

endinterface

// File: rtl/dmaster_rr_pick.sv
// -----------------------------------------------------------------------------
// dmaster_rr_pick
// Combinational round-robin picker. Scans the request vector starting at
// position ptr and wrapping modulo NUM_IN; the first set request wins.
// Ports:
//   req  [NUM_IN] : request vector
//   ptr  [IDX_W]  : first index to examine (must be < NUM_IN)
//   gnt  [NUM_IN] : one-hot winner (all zero when nothing requests)
//   idx  [IDX_W]  : binary index of the winner (0 when nothing requests)
//   any           : at least one request present
// -----------------------------------------------------------------------------
module dmaster_rr_pick
  import dmaster_chan_arbiter_pkg::*;
#(
  parameter  int NUM_IN = NUM_IN_DEF,
  localparam int IDX_W  = idx_w(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_IN-1:0] gnt,
  output logic [IDX_W-1:0]  idx,
  output logic              any
);

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      int              pos;
      logic [IDX_W-1:0] pos_w;
      pos   = (int'(ptr) + k) % NUM_IN;
      pos_w = IDX_W'(pos);
      if (!any && req[pos_w]) begin
        any        = 1'b1;
        gnt[pos_w] = 1'b1;
        idx        = pos_w;
      end
    end
  end

endmodule

// File: rtl/dmaster_chan_arbiter.sv
// -----------------------------------------------------------------------------
// dmaster_chan_arbiter
// Packet-aware N:1 stream arbiter. In IDLE it picks the next input offering a
// start-of-packet (round-robin after the last owner) and locks onto it until
// that input's end-of-packet beat is accepted. Accepted beats are registered
// into a single output stage (latency 1) tagged with the source index.
// Beats arriving in IDLE without SOP are drained and flagged; SOP seen on a
// non-first beat of a locked packet is forwarded but flagged.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : dmaster_chan_arbiter_if.slave (all stream signals + proto_err)
// -----------------------------------------------------------------------------
module dmaster_chan_arbiter
  import dmaster_chan_arbiter_pkg::*;
#(
  parameter int NUM_IN = NUM_IN_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CHAN_W = CHAN_W_DEF
) (
  input logic                   clk,
  input logic                   reset,
  dmaster_chan_arbiter_if.slave bus
);

  localparam int IDX_W = idx_w(NUM_IN);

  // FSM and grant bookkeeping
  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [NUM_IN-1:0] grant_oh_q, grant_oh_d;
  logic [IDX_W-1:0]  last_grant_q, last_grant_d;
  logic              first_q, first_d;

  // Output register stage
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CHAN_W-1:0] out_channel_q, out_channel_d;
  logic              out_sop_q, out_sop_d;
  logic              out_eop_q, out_eop_d;

  logic [NUM_IN-1:0] proto_err_q, proto_err_d;

  // Combinational helpers
  logic [IDX_W-1:0]  rr_ptr;
  logic [NUM_IN-1:0] pick_gnt;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;
  logic [NUM_IN-1:0] in_ready;
  logic              out_free;
  logic              g_valid, g_sop, g_eop;
  logic [DATA_W-1:0] g_data;
  logic              acc;

  // Search starts just after the previous owner so every input gets a turn.
  assign rr_ptr = (last_grant_q == IDX_W'(NUM_IN - 1)) ? '0
                                                       : last_grant_q + IDX_W'(1);

  dmaster_rr_pick #(.NUM_IN(NUM_IN)) u_pick (
    .req (bus.in_valid & bus.in_startofpacket),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // The single output register can take a new beat when empty or draining.
  assign out_free = bus.out_ready || !out_valid_q;

  // Select the granted input's beat.
  always_comb begin
    g_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant_oh_q[i]) g_data = bus.in_data[i*DATA_W +: DATA_W];
    end
  end

  assign g_valid = |(bus.in_valid         & grant_oh_q);
  assign g_sop   = |(bus.in_startofpacket & grant_oh_q);
  assign g_eop   = |(bus.in_endofpacket   & grant_oh_q);

  assign acc = (state_q == ST_LOCKED) && g_valid && |(in_ready & grant_oh_q);

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      grant_oh_q   <= '0;
      last_grant_q <= IDX_W'(NUM_IN - 1);
      first_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      grant_oh_q   <= grant_oh_d;
      last_grant_q <= last_grant_d;
      first_q      <= first_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    grant_oh_d   = grant_oh_q;
    last_grant_d = last_grant_q;
    first_d      = first_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d    = ST_LOCKED;
          grant_d    = pick_idx;
          grant_oh_d = pick_gnt;
          first_d    = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (acc) begin
          first_d = 1'b0;
          if (g_eop) begin
            state_d      = ST_IDLE;
            grant_oh_d   = '0;
            last_grant_d = grant_q;
          end
        end
      end
      default: begin
        state_d    = ST_IDLE;
        grant_oh_d = '0;
      end
    endcase
  end

  // FSM outputs: ready is withheld during reset so nothing is consumed that
  // the reset would then discard. In IDLE, orphan (non-SOP) beats are drained.
  always_comb begin
    in_ready = '0;
    if (!reset) begin
      if (state_q == ST_LOCKED) begin
        in_ready = grant_oh_q & {NUM_IN{out_free}};
      end else begin
        in_ready = bus.in_valid & ~bus.in_startofpacket;
      end
    end
  end

  // Output stage and error flags: next values
  always_comb begin
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_channel_d = out_channel_q;
    out_sop_d     = out_sop_q;
    out_eop_d     = out_eop_q;
    proto_err_d   = proto_err_q;

    if (acc) begin
      out_valid_d   = 1'b1;
      out_data_d    = g_data;
      out_channel_d = CHAN_W'(grant_q);
      out_sop_d     = g_sop;
      out_eop_d     = g_eop;
    end else if (bus.out_ready) begin
      out_valid_d   = 1'b0;
    end

    // Drained orphan beats in IDLE.
    if (state_q == ST_IDLE) begin
      proto_err_d = proto_err_d | (bus.in_valid & in_ready);
    end
    // Restart marker inside an already-open packet.
    if (acc && !first_q && g_sop) begin
      proto_err_d = proto_err_d | grant_oh_q;
    end
  end

  // Output stage and error flags: registers
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_channel_q <= '0;
      out_sop_q     <= 1'b0;
      out_eop_q     <= 1'b0;
      proto_err_q   <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_channel_q <= out_channel_d;
      out_sop_q     <= out_sop_d;
      out_eop_q     <= out_eop_d;
      proto_err_q   <= proto_err_d;
    end
  end

  assign bus.in_ready          = in_ready;
  assign bus.out_valid         = out_valid_q;
  assign bus.out_data          = out_data_q;
  assign bus.out_channel       = out_channel_q;
  assign bus.out_startofpacket = out_sop_q;
  assign bus.out_endofpacket   = out_eop_q;
  assign bus.proto_err         = proto_err_q;

endmodule

// File: tb/tb_dmaster_chan_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmaster_chan_arbiter
// Directed bench for dmaster_chan_arbiter (NUM_IN=4, DATA_W=8, CHAN_W=8).
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge. Packet scenarios use small per-input beat queues whose
// forwarded output beats are logged and compared with hand-written tables.
// -----------------------------------------------------------------------------
module tb_dmaster_chan_arbiter;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  dmaster_chan_arbiter_if #(.NUM_IN(4), .DATA_W(8), .CHAN_W(8)) bus ();

  dmaster_chan_arbiter #(.NUM_IN(4), .DATA_W(8), .CHAN_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  logic [9:0]  srcq [4][$];   // {sop, eop, data}
  logic [17:0] log_q[$];      // {channel, sop, eop, data}
  int          log_cyc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] ent(input logic [7:0] ch, input logic s,
                                      input logic e, input logic [7:0] d);
    return {ch, s, e, d};
  endfunction

  function automatic logic [9:0] bt(input logic s, input logic e, input logic [7:0] d);
    return {s, e, d};
  endfunction

  task automatic chk_out(input string tag, input logic v, input logic [7:0] ch,
                         input logic s, input logic e, input logic [7:0] d);
    chk(tag, {13'd0, bus.out_valid, bus.out_channel, bus.out_startofpacket,
              bus.out_endofpacket, bus.out_data},
        {13'd0, v, ch, s, e, d});
  endtask

  task automatic chk_log(input string tag, input int idx, input logic [17:0] exp);
    if (idx < log_q.size()) chk(tag, {14'd0, log_q[idx]}, {14'd0, exp});
    else                    chk(tag, 32'hFFFF_FFFF, {14'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    bus.in_valid         = '0;
    bus.in_data          = '0;
    bus.in_startofpacket = '0;
    bus.in_endofpacket   = '0;
  endtask

  task automatic drive(input int i, input logic s, input logic e, input logic [7:0] d);
    bus.in_valid[i]         = 1'b1;
    bus.in_startofpacket[i] = s;
    bus.in_endofpacket[i]   = e;
    bus.in_data[i*8 +: 8]   = d;
  endtask

  task automatic idle_in(input int i);
    bus.in_valid[i]         = 1'b0;
    bus.in_startofpacket[i] = 1'b0;
    bus.in_endofpacket[i]   = 1'b0;
    bus.in_data[i*8 +: 8]   = 8'h00;
  endtask

  // Present queued beats for n cycles, pop a beat when it is accepted,
  // and log every beat the sink takes.
  task automatic run(input int n);
    logic [3:0] take;
    logic [9:0] b;
    tick();
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 4; i++) begin
        if (srcq[i].size() != 0) begin
          b = srcq[i][0];
          drive(i, b[9], b[8], b[7:0]);
        end else begin
          idle_in(i);
        end
      end
      @(negedge clk);
      take = bus.in_valid & bus.in_ready;
      if (bus.out_valid && bus.out_ready) begin
        log_q.push_back({bus.out_channel, bus.out_startofpacket,
                         bus.out_endofpacket, bus.out_data});
        log_cyc.push_back(cyc);
      end
      tick();
      cyc++;
      for (int i = 0; i < 4; i++) begin
        if (take[i]) void'(srcq[i].pop_front());
      end
    end
    clr_in();
  endtask

  initial begin
    reset         = 1'b1;
    bus.out_ready = 1'b1;
    clr_in();

    // ---- reset values
    tick(); tick();
    @(negedge clk);
    chk_out("rst_out", 0, 8'd0, 0, 0, 8'h00);
    chk("rst_ready", {28'd0, bus.in_ready}, 32'h0);
    chk("rst_perr",  {28'd0, bus.proto_err}, 32'h0);

    // ---- 3-beat packet on input 0, latency 1
    tick(); reset = 1'b0; drive(0, 1, 0, 8'h11);
    @(negedge clk);
    chk("b_grant_cycle_rdy", {28'd0, bus.in_ready}, 32'h0);
    tick();
    @(negedge clk);
    chk("b_locked_rdy", {28'd0, bus.in_ready}, 32'h1);
    chk_out("b_out_empty", 0, 8'd0, 0, 0, 8'h00);
    tick(); drive(0, 0, 0, 8'h22);
    @(negedge clk);
    chk_out("b_beat0", 1, 8'd0, 1, 0, 8'h11);
    tick(); drive(0, 0, 1, 8'h33);
    @(negedge clk);
    chk_out("b_beat1", 1, 8'd0, 0, 0, 8'h22);
    tick(); clr_in();
    @(negedge clk);
    chk_out("b_beat2", 1, 8'd0, 0, 1, 8'h33);
    chk("b_idle_rdy", {28'd0, bus.in_ready}, 32'h0);
    tick();
    @(negedge clk);
    chk("b_drain", {31'd0, bus.out_valid}, 32'h0);

    // ---- round-robin order 0,1,2,0 from a fresh reset
    reset = 1'b1; tick(); reset = 1'b0;
    log_q.delete(); log_cyc.delete();
    srcq[0].push_back(bt(1, 0, 8'hA0)); srcq[0].push_back(bt(0, 1, 8'hA1));
    srcq[0].push_back(bt(1, 0, 8'hD0)); srcq[0].push_back(bt(0, 1, 8'hD1));
    srcq[1].push_back(bt(1, 0, 8'hB0)); srcq[1].push_back(bt(0, 1, 8'hB1));
    srcq[2].push_back(bt(1, 0, 8'hC0)); srcq[2].push_back(bt(0, 1, 8'hC1));
    run(20);
    chk("rr_len", log_q.size(), 8);
    chk_log("rr_0", 0, ent(8'd0, 1, 0, 8'hA0));
    chk_log("rr_1", 1, ent(8'd0, 0, 1, 8'hA1));
    chk_log("rr_2", 2, ent(8'd1, 1, 0, 8'hB0));
    chk_log("rr_3", 3, ent(8'd1, 0, 1, 8'hB1));
    chk_log("rr_4", 4, ent(8'd2, 1, 0, 8'hC0));
    chk_log("rr_5", 5, ent(8'd2, 0, 1, 8'hC1));
    chk_log("rr_6", 6, ent(8'd0, 1, 0, 8'hD0));
    chk_log("rr_7", 7, ent(8'd0, 0, 1, 8'hD1));

    // ---- single-beat packet on input 3 ahead of input 1 (pointer past 2)
    log_q.delete(); log_cyc.delete();
    srcq[2].push_back(bt(1, 1, 8'h5C));
    run(4);
    srcq[3].push_back(bt(1, 1, 8'hA5));
    srcq[1].push_back(bt(1, 0, 8'h31)); srcq[1].push_back(bt(0, 1, 8'h32));
    run(10);
    chk("sb_len", log_q.size(), 4);
    chk_log("sb_0", 0, ent(8'd2, 1, 1, 8'h5C));
    chk_log("sb_1", 1, ent(8'd3, 1, 1, 8'hA5));
    chk_log("sb_2", 2, ent(8'd1, 1, 0, 8'h31));
    chk_log("sb_3", 3, ent(8'd1, 0, 1, 8'h32));
    if (log_cyc.size() >= 3) chk("sb_gap", log_cyc[2] - log_cyc[1], 2);
    else                     chk("sb_gap", 32'hFFFF_FFFF, 2);
    chk("sb_perr", {28'd0, bus.proto_err}, 32'h0);

    // ---- back-pressure for 4 cycles mid-packet on input 2
    tick(); drive(2, 1, 0, 8'h41);
    @(negedge clk);
    chk("bp_grant_rdy", {28'd0, bus.in_ready}, 32'h0);
    tick();
    @(negedge clk);
    chk("bp_rdy0", {28'd0, bus.in_ready}, 32'h4);
    tick(); drive(2, 0, 0, 8'h42);
    @(negedge clk);
    chk_out("bp_b0", 1, 8'd2, 1, 0, 8'h41);
    chk("bp_rdy1", {28'd0, bus.in_ready}, 32'h4);
    tick(); drive(2, 0, 1, 8'h43); bus.out_ready = 1'b0;
    @(negedge clk);
    chk_out("bp_hold0", 1, 8'd2, 0, 0, 8'h42);
    chk("bp_hold_rdy0", {28'd0, bus.in_ready}, 32'h0);
    for (int s = 1; s < 4; s++) begin
      tick();
      @(negedge clk);
      chk_out($sformatf("bp_hold%0d", s), 1, 8'd2, 0, 0, 8'h42);
      chk($sformatf("bp_hold_rdy%0d", s), {28'd0, bus.in_ready}, 32'h0);
    end
    tick(); bus.out_ready = 1'b1;
    @(negedge clk);
    chk_out("bp_release", 1, 8'd2, 0, 0, 8'h42);
    chk("bp_release_rdy", {28'd0, bus.in_ready}, 32'h4);
    tick(); clr_in();
    @(negedge clk);
    chk_out("bp_last", 1, 8'd2, 0, 1, 8'h43);
    tick();
    @(negedge clk);
    chk("bp_drain", {31'd0, bus.out_valid}, 32'h0);

    // ---- orphan beat (no SOP) on input 1 while idle
    tick(); drive(1, 0, 0, 8'h7E);
    @(negedge clk);
    chk("orph_rdy", {28'd0, bus.in_ready}, 32'h2);
    tick(); clr_in();
    @(negedge clk);
    chk("orph_perr", {28'd0, bus.proto_err}, 32'h2);
    chk("orph_outv", {31'd0, bus.out_valid}, 32'h0);
    log_q.delete(); log_cyc.delete();
    srcq[1].push_back(bt(1, 0, 8'h51)); srcq[1].push_back(bt(0, 1, 8'h52));
    run(6);
    chk("orph_len", log_q.size(), 2);
    chk_log("orph_p0", 0, ent(8'd1, 1, 0, 8'h51));
    chk_log("orph_p1", 1, ent(8'd1, 0, 1, 8'h52));
    chk("orph_perr_keep", {28'd0, bus.proto_err}, 32'h2);

    // ---- repeated SOP inside a packet on input 0: forwarded and flagged
    log_q.delete(); log_cyc.delete();
    srcq[0].push_back(bt(1, 0, 8'h61));
    srcq[0].push_back(bt(1, 0, 8'h62));
    srcq[0].push_back(bt(0, 1, 8'h63));
    run(7);
    chk("dsop_len", log_q.size(), 3);
    chk_log("dsop_0", 0, ent(8'd0, 1, 0, 8'h61));
    chk_log("dsop_1", 1, ent(8'd0, 1, 0, 8'h62));
    chk_log("dsop_2", 2, ent(8'd0, 0, 1, 8'h63));
    chk("dsop_perr", {28'd0, bus.proto_err}, 32'h3);

    // ---- reset on beat 2 of a packet on input 1
    tick(); drive(1, 1, 0, 8'h81);
    @(negedge clk);
    chk("mr_grant_rdy", {28'd0, bus.in_ready}, 32'h0);
    tick();
    @(negedge clk);
    chk("mr_rdy", {28'd0, bus.in_ready}, 32'h2);
    tick(); drive(1, 0, 0, 8'h82); reset = 1'b1;
    @(negedge clk);
    chk_out("mr_b0", 1, 8'd1, 1, 0, 8'h81);
    tick(); reset = 1'b0; clr_in();
    @(negedge clk);
    chk_out("mr_rst_out", 0, 8'd0, 0, 0, 8'h00);
    chk("mr_rst_rdy",  {28'd0, bus.in_ready}, 32'h0);
    chk("mr_rst_perr", {28'd0, bus.proto_err}, 32'h0);
    tick(); drive(0, 1, 1, 8'h90); drive(1, 1, 1, 8'h91);
    @(negedge clk);
    chk("mr_idle_rdy", {28'd0, bus.in_ready}, 32'h0);
    tick();
    @(negedge clk);
    chk("mr_prio_rdy", {28'd0, bus.in_ready}, 32'h1);
    tick(); idle_in(0);
    @(negedge clk);
    chk_out("mr_out0", 1, 8'd0, 1, 1, 8'h90);
    chk("mr_gap_rdy", {28'd0, bus.in_ready}, 32'h0);
    tick();
    @(negedge clk);
    chk("mr_next_rdy", {28'd0, bus.in_ready}, 32'h2);
    tick(); clr_in();
    @(negedge clk);
    chk_out("mr_out1", 1, 8'd1, 1, 1, 8'h91);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmaster_chan_arbiter.md
DMASTER_CHAN_ARBITER -- requirements
Module: dmaster_chan_arbiter

Interface
REQ-001 SHALL have parameter NUM_IN, default 4, meaning number of input streams (2..8).
REQ-002 SHALL have parameter DATA_W, default 8, meaning symbol width.
REQ-003 SHALL have parameter CHAN_W, default 8, meaning output channel field width.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  NUM_IN  per-input beat valid.
REQ-007 in_ready  output  NUM_IN  per-input beat accept.
REQ-008 in_data  input  NUM_IN*DATA_W  per-input data; input i occupies bits [i*DATA_W +: DATA_W].
REQ-009 in_startofpacket  input  NUM_IN  per-input SOP.
REQ-010 in_endofpacket  input  NUM_IN  per-input EOP.
REQ-011 out_ready  input  1  downstream accept.
REQ-012 out_valid  output  1  output beat valid.
REQ-013 out_data  output  DATA_W  output data.
REQ-014 out_channel  output  CHAN_W  index of the source input, zero-extended.
REQ-015 out_startofpacket, out_endofpacket  output  1 each  forwarded SOP/EOP.
REQ-016 proto_err  output  NUM_IN  sticky per-input framing-error flags.

Function
REQ-017 SHALL implement two states, IDLE (no grant) and LOCKED (one input granted until its EOP beat is accepted).
REQ-018 In IDLE, SHALL grant the first input i with in_valid[i] && in_startofpacket[i], searching round-robin from (last_grant+1) mod NUM_IN, then enter LOCKED.
REQ-019 A transfer SHALL occur on input i when in_valid[i] && in_ready[i].
REQ-020 Granted input ready SHALL be out_ready || !out_valid (single-register pipeline); non-granted inputs SHALL have ready 0, except under REQ-023.
REQ-021 Each accepted beat SHALL appear on the output registers on the next cycle (latency 1), with out_channel equal to the grant index.
REQ-022 out_* SHALL hold stable while out_valid && !out_ready; out_valid SHALL clear after acceptance if no new beat is loaded.
REQ-023 In IDLE, an input with in_valid && !in_startofpacket SHALL get ready 1, its beat SHALL be dropped, and its proto_err bit SHALL be set.
REQ-024 In LOCKED, SOP on a non-first beat of the granted input SHALL be forwarded unchanged and SHALL set that input's proto_err bit.
REQ-025 Acceptance of an EOP beat SHALL return the FSM to IDLE and update last_grant; arbitration for the next packet SHALL start the following cycle (one idle grant cycle per packet).
REQ-026 A beat with SOP and EOP both set SHALL be a complete single-beat packet per REQ-025.
REQ-027 The grant SHALL NOT change mid-packet, regardless of other requests.
REQ-028 proto_err bits SHALL clear only on reset.

Reset
REQ-029 On reset, SHALL enter IDLE, set last_grant to NUM_IN-1 (so input 0 has first priority), clear the output register, and clear proto_err.
REQ-030 Reset outputs SHALL be out_valid=0, out_data=0, out_channel=0, out_startofpacket=0, out_endofpacket=0, in_ready=0, proto_err=0.
REQ-031 Reset asserted mid-packet SHALL abandon the packet with no EOP emitted.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding (IDLE, LOCKED) and the NUM_IN/DATA_W/CHAN_W defaults.
REQ-033 The round-robin search SHALL be a sub-module named dmaster_rr_pick (request vector and pointer in, one-hot grant and index out, combinational).

Verification
REQ-034 Reset, then input 0 sends a 3-beat packet 0x11,0x22,0x33 with out_ready=1 -> output shows the same bytes one cycle later, channel=0, SOP on 0x11, EOP on 0x33.
REQ-035 Inputs 0, 1 and 2 each hold a pending 2-beat packet from reset -> output packet order is channels 0,1,2,0 with no interleaving within a packet.
REQ-036 Input 3 sends a single-beat SOP+EOP 0xA5 while input 1 waits -> output is 0xA5 on channel 3, then input 1's packet starts after exactly one grant cycle.
REQ-037 out_ready held low for 4 cycles mid-packet on input 2 -> out_* stable, in_ready[2]=0, no beat lost or duplicated after release.
REQ-038 Input 1 sends valid without SOP in IDLE (0x7E) -> beat dropped, proto_err=4'b0010, output idle; a later valid packet on input 1 passes normally.
REQ-039 Reset asserted on beat 2 of a 4-beat packet -> next cycle all outputs are at reset values, and the next SOP on input 0 is granted first.
